// File: rtl/led_seq_pkg.sv
// LED sequencer shared definitions.
// Register map, step modes and FSM states.
package led_seq_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_PATTERN = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/led_seq_timer.sv
// Step-period down-counter.
// tick fires in the cycle the count reaches zero.
module led_seq_timer #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             en,
  output logic             tick
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  // load wins over count-down; count saturates at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // the decrement from 1 to 0 (or an already-zero count) ends the wait
  assign tick = en && !load && (count_q <= DIV_W'(1));

  // counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: config slave in,
// periodic PIO writes of the current pattern out.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int LED_W = 10,
  parameter int DIV_W = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  state_e           state_q, state_d;
  logic             run_q, run_d;
  mode_e            mode_q, mode_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [LED_W-1:0] pattern_q, pattern_d;
  logic [LED_W-1:0] cur_q, cur_d;
  logic             dir_q, dir_d;
  logic             pend_q, pend_d;
  logic             m_cs_q, m_cs_d;
  logic             m_wn_q, m_wn_d;
  logic [31:0]      m_wd_q, m_wd_d;

  logic             wr_en;
  logic             ctrl_wr;
  logic             period_wr;
  logic             pat_wr;
  logic             run_eff;
  logic [LED_W-1:0] pat_eff;
  logic             busy;
  logic             accept;
  logic             tick;
  logic [DIV_W-1:0] load_val;
  logic [LED_W-1:0] step_cur;
  logic             step_dir;
  logic             unused_wdata;

  assign wr_en     = s_chipselect && !s_write_n;
  assign ctrl_wr   = wr_en && (s_address == REG_CTRL);
  assign period_wr = wr_en && (s_address == REG_PERIOD);
  assign pat_wr    = wr_en && (s_address == REG_PATTERN);

  // a write landing this cycle is seen by the FSM immediately
  assign run_eff = ctrl_wr ? s_writedata[0] : run_q;
  assign pat_eff = pat_wr ? s_writedata[LED_W-1:0] : pattern_q;

  assign busy   = (state_q != ST_IDLE);
  assign accept = (state_q == ST_WRITE) && !m_waitrequest;

  // a zero period behaves like a period of one
  assign load_val = (period_q == '0) ? '0 : period_q - 1'b1;

  assign unused_wdata = ^s_writedata;

  led_seq_timer #(
    .DIV_W(DIV_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .load_val(load_val),
    .en      (state_q == ST_WAIT),
    .tick    (tick)
  );

  // next pattern for the current mode
  always_comb begin
    step_cur = cur_q;
    step_dir = dir_q;
    unique case (mode_q)
      MODE_STATIC: step_cur = cur_q;
      MODE_ROTATE: step_cur = {cur_q[LED_W-2:0], cur_q[LED_W-1]};
      MODE_BOUNCE: begin
        if (!dir_q) begin
          if (cur_q[LED_W-1]) begin
            step_dir = 1'b1;
            step_cur = cur_q >> 1;
          end else begin
            step_cur = cur_q << 1;
          end
        end else begin
          if (cur_q[0]) begin
            step_dir = 1'b0;
            step_cur = cur_q << 1;
          end else begin
            step_cur = cur_q >> 1;
          end
        end
      end
      MODE_BLINK:  step_cur = ~cur_q;
      default:     step_cur = cur_q;
    endcase
  end

  // register file, FSM and PIO output next-state
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    mode_d    = mode_q;
    period_d  = period_q;
    pattern_d = pattern_q;
    cur_d     = cur_q;
    dir_d     = dir_q;
    pend_d    = pend_q;

    if (ctrl_wr) begin
      run_d  = s_writedata[0];
      mode_d = mode_e'(s_writedata[2:1]);
    end
    if (period_wr) begin
      period_d = s_writedata[DIV_W-1:0];
    end
    if (pat_wr) begin
      pattern_d = s_writedata[LED_W-1:0];
      if (busy) pend_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (run_eff) begin
          cur_d   = pat_eff;
          dir_d   = 1'b0;
          pend_d  = 1'b0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (accept) begin
          state_d = run_eff ? ST_WAIT : ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!run_eff) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          state_d = ST_WRITE;
          if (pend_q || pat_wr) begin
            cur_d  = pat_eff;
            pend_d = 1'b0;
          end else begin
            cur_d = step_cur;
            dir_d = step_dir;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    m_cs_d = (state_d == ST_WRITE);
    m_wn_d = !m_cs_d;
    m_wd_d = 32'(cur_d);
  end

  // all state and registered PIO outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      run_q     <= 1'b0;
      mode_q    <= MODE_STATIC;
      period_q  <= '0;
      pattern_q <= '0;
      cur_q     <= '0;
      dir_q     <= 1'b0;
      pend_q    <= 1'b0;
      m_cs_q    <= 1'b0;
      m_wn_q    <= 1'b1;
      m_wd_q    <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      mode_q    <= mode_d;
      period_q  <= period_d;
      pattern_q <= pattern_d;
      cur_q     <= cur_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      m_cs_q    <= m_cs_d;
      m_wn_q    <= m_wn_d;
      m_wd_q    <= m_wd_d;
    end
  end

  assign m_address    = 2'b00;
  assign m_chipselect = m_cs_q;
  assign m_write_n    = m_wn_q;
  assign m_writedata  = m_wd_q;

  // zero-wait config readback
  always_comb begin
    s_readdata = '0;
    unique case (s_address)
      REG_CTRL:    s_readdata = {29'b0, mode_q, run_q};
      REG_PERIOD:  s_readdata = 32'(period_q);
      REG_PATTERN: s_readdata = 32'(pattern_q);
      REG_STATUS: begin
        s_readdata[LED_W-1:0] = cur_q;
        s_readdata[31]        = busy;
      end
      default:     s_readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer.
// Register table plus hand-timed PIO sequences.
module tb_led_sequencer;

  localparam int LED_W = 10;
  localparam int DIV_W = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  s_address;
  logic        s_chipselect;
  logic        s_write_n;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  led_sequencer #(
    .LED_W(LED_W),
    .DIV_W(DIV_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_address    (s_address),
    .s_chipselect (s_chipselect),
    .s_write_n    (s_write_n),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_waitrequest(m_waitrequest)
  );

  always #5 clk = ~clk;

  int vec_n = 0;
  int err_n = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] d;
    int          c;
  } wr_t;
  wr_t q[$];

  typedef struct {
    logic [1:0]  a;
    logic        we;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (m_chipselect && !m_write_n && !m_waitrequest)
      q.push_back('{d: m_writedata, c: cyc});

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    tick();
    s_chipselect = 1'b1;
    s_write_n    = 1'b0;
    s_address    = a;
    s_writedata  = d;
    tick();
    s_chipselect = 1'b0;
    s_write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp,
                    input string name);
    s_address = a;
    #1;
    check(name, s_readdata, exp);
  endtask

  task automatic do_reset();
    tick();
    reset         = 1'b1;
    m_waitrequest = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget,
                             input string name);
    int k = 0;
    while (q.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(name, 32'(q.size()), 32'(n));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi;
    logic [31:0] e;

    reset         = 1'b1;
    s_address     = 2'd0;
    s_chipselect  = 1'b0;
    s_write_n     = 1'b1;
    s_writedata   = '0;
    m_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_cs", 32'(m_chipselect), 32'd0);
    check("rst_wn", 32'(m_write_n), 32'd1);
    check("rst_wd", m_writedata, 32'd0);
    check("rst_maddr", 32'(m_address), 32'd0);
    for (int i = 0; i < 4; i++) rd(2'(i), 32'd0, "rst_reg");

    tbl[0] = '{2'd0, 1'b1, 32'hFFFF_FFF4, 32'h0000_0004};
    tbl[1] = '{2'd1, 1'b1, 32'hFFFF_FFFF, 32'h00FF_FFFF};
    tbl[2] = '{2'd2, 1'b1, 32'hFFFF_FC01, 32'h0000_0001};
    tbl[3] = '{2'd3, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[4] = '{2'd0, 1'b1, 32'h0000_0002, 32'h0000_0002};
    tbl[5] = '{2'd2, 1'b1, 32'h0000_02AA, 32'h0000_02AA};
    tbl[6] = '{2'd1, 1'b1, 32'h0012_3456, 32'h0012_3456};
    tbl[7] = '{2'd0, 1'b0, 32'h0000_0000, 32'h0000_0002};
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].we) wr(tbl[i].a, tbl[i].wd);
      rd(tbl[i].a, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // rotate, period 4
    do_reset();
    wr(2'd2, 32'h001);
    wr(2'd1, 32'd4);
    q.delete();
    wr(2'd0, 32'h3);
    wait_writes(12, 200, "rot_cnt");
    if (q.size() >= 12) begin
      for (int i = 0; i < 12; i++) begin
        e = (i < 10) ? (32'd1 << i) : (32'd1 << (i - 10));
        check($sformatf("rot_d%0d", i), q[i].d, e);
        if (i > 0)
          check($sformatf("rot_gap%0d", i),
                32'(q[i].c - q[i-1].c), 32'd4);
      end
    end

    // pattern write while busy replaces the next step
    hi = q.size();
    wait_writes(hi + 1, 20, "pat_sync");
    wr(2'd2, 32'h300);
    q.delete();
    wait_writes(2, 40, "pat_cnt");
    if (q.size() >= 2) begin
      check("pat_d0", q[0].d, 32'h300);
      check("pat_d1", q[1].d, 32'h201);
    end
    wr(2'd0, 32'h0);

    // bounce, period 1
    do_reset();
    wr(2'd2, 32'h001);
    wr(2'd1, 32'd1);
    q.delete();
    wr(2'd0, 32'h5);
    wait_writes(20, 200, "bnc_cnt");
    if (q.size() >= 20) begin
      for (int i = 0; i < 20; i++) begin
        if (i < 10) e = 32'd1 << i;
        else if (i < 19) e = 32'd1 << (18 - i);
        else e = 32'd2;
        check($sformatf("bnc_d%0d", i), q[i].d, e);
      end
    end

    // blink with a 3-cycle stall on the second write
    do_reset();
    wr(2'd2, 32'h2AA);
    wr(2'd1, 32'd2);
    q.delete();
    wr(2'd0, 32'h7);
    tick();
    tick();
    m_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall_cs%0d", i), 32'(m_chipselect), 32'd1);
      check($sformatf("stall_wd%0d", i), m_writedata, 32'h155);
      check($sformatf("stall_q%0d", i), 32'(q.size()), 32'd1);
      tick();
    end
    m_waitrequest = 1'b0;
    wait_writes(3, 20, "blk_cnt");
    if (q.size() >= 3) begin
      check("blk_d0", q[0].d, 32'h2AA);
      check("blk_d1", q[1].d, 32'h155);
      check("blk_gap1", 32'(q[1].c - q[0].c), 32'd5);
      check("blk_d2", q[2].d, 32'h2AA);
      check("blk_gap2", 32'(q[2].c - q[1].c), 32'd2);
    end

    // run cleared during a long wait
    do_reset();
    wr(2'd2, 32'h001);
    wr(2'd1, 32'd100);
    q.delete();
    wr(2'd0, 32'h3);
    wait_writes(1, 20, "stop_first");
    repeat (10) tick();
    wr(2'd0, 32'h2);
    rd(2'd3, 32'h0000_0001, "stop_status");
    q.delete();
    hi = 0;
    repeat (150) begin
      @(negedge clk);
      if (m_chipselect) hi++;
    end
    check("stop_cs_cycles", 32'(hi), 32'd0);
    check("stop_writes", 32'(q.size()), 32'd0);

    // reset during a stalled write
    do_reset();
    m_waitrequest = 1'b1;
    wr(2'd2, 32'h0F0);
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h3);
    repeat (3) tick();
    rd(2'd3, 32'h8000_00F0, "hang_status");
    check("hang_cs", 32'(m_chipselect), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check("rst2_cs", 32'(m_chipselect), 32'd0);
    check("rst2_wn", 32'(m_write_n), 32'd1);
    check("rst2_wd", m_writedata, 32'd0);
    rd(2'd3, 32'h0, "rst2_status");
    rd(2'd0, 32'h0, "rst2_ctrl");
    rd(2'd1, 32'h0, "rst2_period");
    rd(2'd2, 32'h0, "rst2_pattern");
    reset         = 1'b0;
    m_waitrequest = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter LED_W, default 10, LED port width driven onto the PIO.
REQ-002 SHALL have parameter DIV_W, default 24, step-period counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_address  input  2  config register select.
REQ-006 SHALL have port s_chipselect  input  1  config slave select.
REQ-007 SHALL have port s_write_n  input  1  config write strobe, active low.
REQ-008 SHALL have port s_writedata  input  32  config write data.
REQ-009 SHALL have port s_readdata  output  32  config read data, combinational on s_address, zero wait.
REQ-010 SHALL have port m_address  output  2  PIO register address, constant 0.
REQ-011 SHALL have port m_chipselect  output  1  PIO select.
REQ-012 SHALL have port m_write_n  output  1  PIO write strobe, active low.
REQ-013 SHALL have port m_writedata  output  32  PIO data, {zeros, cur[LED_W-1:0]}.
REQ-014 SHALL have port m_waitrequest  input  1  PIO stall; tie 0 when unused.

Function
REQ-015 SHALL decode registers: 0 CTRL (bit0 run, bits2:1 mode), 1 PERIOD (DIV_W bits), 2 PATTERN (LED_W bits), 3 STATUS (read-only: [LED_W-1:0] cur, bit31 busy); unused bits read 0.
REQ-016 SHALL accept a slave write when s_chipselect=1 and s_write_n=0; writes to STATUS ignored.
REQ-017 SHALL encode mode: 0 static (cur unchanged), 1 rotate-left, 2 bounce, 3 blink (cur <= ~cur).
REQ-018 SHALL rotate as cur <= {cur[LED_W-2:0], cur[LED_W-1]}.
REQ-019 SHALL bounce: shift left while dir=0, right while dir=1; dir toggles in the step after cur[LED_W-1]=1 (left) or cur[0]=1 (right); bounce with cur=0 stays 0.
REQ-020 SHALL implement FSM IDLE, WRITE, WAIT; busy=1 outside IDLE.
REQ-021 IDLE: on run=1, cur <= PATTERN, dir <= 0, go WRITE next cycle.
REQ-022 WRITE: m_chipselect=1, m_write_n=0, m_writedata from cur; hold while m_waitrequest=1; on accept go WAIT, load counter with PERIOD-1 (PERIOD=0 treated as 1).
REQ-023 WAIT: decrement counter each cycle; at 0 apply mode step to cur and go WRITE; one PIO write per PERIOD cycles when m_waitrequest=0.
REQ-024 Outside WRITE: m_chipselect=0, m_write_n=1.
REQ-025 run cleared in WAIT: go IDLE next cycle; cleared in WRITE: complete the accepted write, then IDLE; no write aborted mid-stall.
REQ-026 PATTERN write while busy SHALL load cur at the next step in place of the computed value; same-cycle collision with a step: PATTERN wins.
REQ-027 PERIOD write while busy SHALL take effect at the next counter load.
REQ-028 Mode write while busy SHALL take effect at the next step.

Reset
REQ-029 On reset=1 at a clk edge: state IDLE, CTRL/PERIOD/PATTERN/cur/dir/counter = 0, m_chipselect=0, m_write_n=1, m_writedata=0, m_address=0.
REQ-030 Reset SHALL override every other event, including a stalled WRITE; s_readdata reflects zeroed registers in the following cycle.

Structure
REQ-031 Package led_seq_pkg SHALL hold register offsets, mode encoding and FSM state typedef.
REQ-032 Sub-module led_seq_timer SHALL hold the DIV_W down-counter (load, value-in, tick-at-zero).
REQ-033 Next-pattern logic SHALL stay combinational inside led_sequencer; total RTL 120-400 lines.

Verification
REQ-034 PATTERN=0x001, PERIOD=4, mode 1, run=1 -> m_writedata 0x001,0x002,0x004... one write every 4 cycles; 0x200 followed by 0x001.
REQ-035 Mode 2, PATTERN=0x001, PERIOD=1 -> 0x001..0x200 then 0x100..0x001 then 0x002, no repeated endpoint skipped or duplicated beyond one write each.
REQ-036 Mode 3, PATTERN=0x2AA, PERIOD=2, m_waitrequest held 1 for 3 cycles on second write -> 0x2AA, 0x155 delayed 3 cycles, chipselect held steady throughout.
REQ-037 Clear run during WAIT with PERIOD=100 -> busy=0 one cycle later, no further m_chipselect.
REQ-038 Assert reset during stalled WRITE -> next cycle m_chipselect=0, STATUS reads 0x00000000, CTRL reads 0.
